bcd_count_ctrl: RTL and testbench

BCD_COUNT_CTRL -- requirements
Module: bcd_count_ctrl

---
 rtl/bcd_count_ctrl.sv | 114 +++++++++++
 tb/tb_bcd_count_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_count_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// bcd_count_ctrl : start/stop/clear controlled cascaded BCD counter with a
// loadable terminal limit. Optional macro BCD_CTRL_WRAP_EN: wrap on terminal.
// Revision: 1.0
// ============================================================================
module bcd_count_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  tick,
    input  logic                  load_valid,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic                  load_ready,
    output logic [4*DIGITS-1:0]   count,
    output logic [1:0]            state,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

    state_t                cur_state;
    logic [4*DIGITS-1:0]   count_reg;
    logic [4*DIGITS-1:0]   limit;
    logic                  done_reg;
    logic [4*DIGITS-1:0]   load_sat;
    logic [4*DIGITS-1:0]   count_inc;
    logic                  carry;
    logic [3:0]            digit;

    // Out-of-range nibbles are clamped to 9 so the limit is always valid BCD.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_sat
            assign load_sat[4*gi +: 4] = (load_value[4*gi +: 4] > 4'd9) ? 4'd9
                                                                       : load_value[4*gi +: 4];
        end
    endgenerate

    always_comb begin
        count_inc = '0;
        carry     = 1'b1;
        digit     = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            digit = count_reg[4*i +: 4];
            if (carry) begin
                count_inc[4*i +: 4] = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
            end else begin
                count_inc[4*i +: 4] = digit;
            end
            carry = carry & (digit == 4'd9);
        end
    end

    assign load_ready = (cur_state == IDLE) || (cur_state == DONE);
    assign busy       = (cur_state == RUN)  || (cur_state == PAUSE);
    assign state      = cur_state;
    assign count      = count_reg;
    assign done       = done_reg;

    // The if/else chain encodes command priority: clear, load, stop, start, tick.
    // A raised stop always suppresses start, even where stop itself does nothing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= IDLE;
            count_reg <= '0;
            limit     <= ALL_NINES;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (clear) begin
                cur_state <= IDLE;
                count_reg <= '0;
            end else if (load_valid && load_ready) begin
                limit <= load_sat;
            end else if (stop) begin
                if (cur_state == RUN) begin
                    cur_state <= PAUSE;
                end
            end else if (start && (cur_state != RUN)) begin
                if (cur_state != PAUSE) begin
                    count_reg <= '0;
                end
                cur_state <= RUN;
            end else if (tick && (cur_state == RUN)) begin
                if (count_reg == limit) begin
                    done_reg <= 1'b1;
`ifdef BCD_CTRL_WRAP_EN
                    count_reg <= '0;
`else
                    cur_state <= DONE;
`endif
                end else begin
                    count_reg <= count_inc;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_count_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_bcd_count_ctrl : vector table, directed corner sequences and random
// stimulus checked against a decimal-integer reference model.
// ============================================================================
module tb_bcd_count_ctrl;

    localparam int DIGITS = 4;
    localparam int MODN   = 10000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop, clear, tick, load_valid;
    logic [15:0] load_value;
    logic        load_ready;
    logic [15:0] count;
    logic [1:0]  state;
    logic        busy;
    logic        done;

    bcd_count_ctrl #(.DIGITS(DIGITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .tick       (tick),
        .load_valid (load_valid),
        .load_value (load_value),
        .load_ready (load_ready),
        .count      (count),
        .state      (state),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: count and limit kept as plain decimal integers.
    int m_state;
    int m_count;
    int m_limit;
    int m_done;

    typedef struct {
        logic        st, sp, cl, tk, lv;
        logic [15:0] lval;
        logic [15:0] e_count;
        logic [1:0]  e_state;
        logic        e_done;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] b;
        int v;
        b = '0;
        v = n;
        for (int i = 0; i < DIGITS; i++) begin
            b[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return b;
    endfunction

    function automatic int sat_value(input logic [15:0] v);
        int r;
        int d;
        r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) d = 9;
            r = r * 10 + d;
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic st, input logic sp, input logic cl,
                                input logic tk, input logic lv, input logic [15:0] lval,
                                input logic [15:0] ec, input logic [1:0] es, input logic ed);
        vec_t v;
        v.st = st; v.sp = sp; v.cl = cl; v.tk = tk; v.lv = lv; v.lval = lval;
        v.e_count = ec; v.e_state = es; v.e_done = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_count = 0;
        m_limit = MODN - 1;
        m_done  = 0;
    endtask

    task automatic model_step(input logic st, input logic sp, input logic cl,
                              input logic tk, input logic lv, input logic [15:0] lval);
        m_done = 0;
        if (cl) begin
            m_state = 0;
            m_count = 0;
        end else if (lv && (m_state == 0 || m_state == 3)) begin
            m_limit = sat_value(lval);
        end else if (sp) begin
            if (m_state == 1) m_state = 2;
        end else if (st && m_state != 1) begin
            if (m_state != 2) m_count = 0;
            m_state = 1;
        end else if (tk && m_state == 1) begin
            if (m_count == m_limit) begin
                m_done = 1;
`ifdef BCD_CTRL_WRAP_EN
                m_count = 0;
`else
                m_state = 3;
`endif
            end else begin
                m_count = (m_count + 1) % MODN;
            end
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_count"},      32'(count),      32'(to_bcd(m_count)));
        check({tag, "_state"},      32'(state),      32'(m_state));
        check({tag, "_busy"},       32'(busy),       32'(m_state == 1 || m_state == 2));
        check({tag, "_done"},       32'(done),       32'(m_done));
        check({tag, "_load_ready"}, 32'(load_ready), 32'(m_state == 0 || m_state == 3));
    endtask

    task automatic drive(input logic st, input logic sp, input logic cl,
                         input logic tk, input logic lv, input logic [15:0] lval);
        start = st; stop = sp; clear = cl; tick = tk; load_valid = lv; load_value = lval;
    endtask

    task automatic step(input logic st, input logic sp, input logic cl,
                        input logic tk, input logic lv, input logic [15:0] lval);
        drive(st, sp, cl, tk, lv, lval);
        model_step(st, sp, cl, tk, lv, lval);
        @(posedge clk);
        #1;
        compare_model("step");
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        rst = 1'b0;
        #2;
        model_reset();
        compare_model("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

        // Load 0012, start, 13 ticks, terminal on the 13th.
        vecs[0] = mk(0, 0, 0, 0, 1, 16'h0012, 16'h0000, 2'b00, 1'b0);
        vecs[1] = mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 2'b01, 1'b0);
        for (int i = 1; i <= 12; i++)
            vecs[1+i] = mk(0, 0, 0, 1, 0, 16'h0000, to_bcd(i), 2'b01, 1'b0);
`ifdef BCD_CTRL_WRAP_EN
        vecs[14] = mk(0, 0, 0, 1, 0, 16'h0000, 16'h0000, 2'b01, 1'b1);
        vecs[15] = mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 2'b01, 1'b0);
`else
        vecs[14] = mk(0, 0, 0, 1, 0, 16'h0000, 16'h0012, 2'b11, 1'b1);
        vecs[15] = mk(0, 0, 0, 0, 0, 16'h0000, 16'h0012, 2'b11, 1'b0);
`endif

        #1;
        do_reset();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_load_ready", 32'(load_ready), 32'd1);

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].st, vecs[i].sp, vecs[i].cl, vecs[i].tk, vecs[i].lv, vecs[i].lval);
            model_step(vecs[i].st, vecs[i].sp, vecs[i].cl, vecs[i].tk, vecs[i].lv, vecs[i].lval);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
            check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].e_state));
            check($sformatf("vec%0d_done", i),  32'(done),  32'(vecs[i].e_done));
        end

        // Carry across digits and terminal at the all-nines limit.
        do_reset();
        step(1, 0, 0, 0, 0, 16'h0000);
        ticks(99);
        check("cnt_0099", 32'(count), 32'h0099);
        ticks(1);
        check("cnt_0100", 32'(count), 32'h0100);
        ticks(9899);
        check("cnt_9999", 32'(count), 32'h9999);
        ticks(1);
        check("term9999_done", 32'(done), 32'd1);
`ifdef BCD_CTRL_WRAP_EN
        check("term9999_count", 32'(count), 32'h0000);
        check("term9999_state", 32'(state), 32'd1);
`else
        check("term9999_count", 32'(count), 32'h9999);
        check("term9999_state", 32'(state), 32'd3);
`endif

        // stop+start together pauses; tick in PAUSE ignored; start resumes.
        do_reset();
        step(1, 0, 0, 0, 0, 16'h0000);
        ticks(5);
        step(1, 1, 0, 0, 0, 16'h0000);
        check("pause_state", 32'(state), 32'd2);
        check("pause_count", 32'(count), 32'h0005);
        ticks(1);
        check("pause_tick_count", 32'(count), 32'h0005);
        step(1, 0, 0, 0, 0, 16'h0000);
        check("resume_state", 32'(state), 32'd1);
        check("resume_count", 32'(count), 32'h0005);
        ticks(1);
        check("resume_tick", 32'(count), 32'h0006);

        // Load refused in RUN; nibble saturation in IDLE.
        do_reset();
        step(1, 0, 0, 0, 0, 16'h0000);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0003);
        #1;
        check("run_load_ready", 32'(load_ready), 32'd0);
        model_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0003);
        @(posedge clk);
        #1;
        compare_model("run_load");
        ticks(5);
        check("run_load_ignored_count", 32'(count), 32'h0005);
        check("run_load_ignored_state", 32'(state), 32'd1);
        step(0, 0, 1, 0, 0, 16'h0000);
        step(0, 0, 0, 0, 1, 16'h00A3);
        step(1, 0, 0, 0, 0, 16'h0000);
        ticks(93);
        check("sat_cnt_0093", 32'(count), 32'h0093);
        ticks(1);
        check("sat_term_done", 32'(done), 32'd1);

        // Asynchronous reset in mid-cycle, limit returns to all nines.
        do_reset();
        step(0, 0, 0, 0, 1, 16'h0050);
        step(1, 0, 0, 0, 0, 16'h0000);
        ticks(42);
        check("pre_rst_count", 32'(count), 32'h0042);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_count", 32'(count), 32'h0000);
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_load_ready", 32'(load_ready), 32'd1);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1, 0, 0, 0, 0, 16'h0000);
        ticks(51);
        check("post_rst_limit_count", 32'(count), 32'h0051);
        check("post_rst_limit_state", 32'(state), 32'd1);

        // clear beats a simultaneous tick and load.
        do_reset();
        step(0, 0, 0, 0, 1, 16'h0003);
        step(1, 0, 0, 0, 0, 16'h0000);
        ticks(2);
        step(0, 0, 1, 1, 1, 16'h0001);
        check("clear_state", 32'(state), 32'd0);
        check("clear_count", 32'(count), 32'h0000);
        check("clear_done", 32'(done), 32'd0);
        step(0, 0, 0, 0, 0, 16'h0000);
        check("clear_done_next", 32'(done), 32'd0);
        step(1, 0, 0, 0, 0, 16'h0000);
        ticks(3);
        check("clear_keep_limit", 32'(count), 32'h0003);
        ticks(1);
        check("clear_keep_limit_done", 32'(done), 32'd1);

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            logic        r_st, r_sp, r_cl, r_tk, r_lv;
            logic [15:0] r_val;
            r_st  = ($urandom_range(0, 7) == 0);
            r_sp  = ($urandom_range(0, 14) == 0);
            r_cl  = ($urandom_range(0, 59) == 0);
            r_tk  = ($urandom_range(0, 3) != 0);
            r_lv  = ($urandom_range(0, 5) == 0);
            r_val = ($urandom_range(0, 1) == 0) ? to_bcd($urandom_range(0, 30))
                                                : 16'($urandom);
            step(r_st, r_sp, r_cl, r_tk, r_lv, r_val);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
